// File: rtl/conv_weight_streamer_if.sv
// rtl/conv_weight_streamer_if.sv - RAM read port and kernel stream bundle for conv_weight_streamer
//
// Purpose: groups the conv weight RAM read port and the kernel valid/ready
// stream so the streamer and its neighbours share one connection.
// Signals:
//   ram_addr  streamer -> RAM       read address (ADDR_W)
//   ram_q     RAM -> streamer       read data, one cycle after the address
//   k_data    streamer -> datapath  packed kernel (8*KSIZE)
//   k_valid   streamer -> datapath  kernel available
//   k_ready   datapath -> streamer  kernel accepted
// Modports: master = streamer side, slave = RAM/datapath side.
interface conv_weight_streamer_if #(
  parameter int ADDR_W = 16,
  parameter int KSIZE  = 9
);
  logic [ADDR_W-1:0]  ram_addr;
  logic [7:0]         ram_q;
  logic [8*KSIZE-1:0] k_data;
  logic               k_valid;
  logic               k_ready;

  modport master (
    output ram_addr, k_data, k_valid,
    input  ram_q, k_ready
  );

  modport slave (
    input  ram_addr, k_data, k_valid,
    output ram_q, k_ready
  );
endinterface

// File: rtl/conv_weight_streamer.sv
// rtl/conv_weight_streamer.sv - walks the conv weight RAM and streams packed KSIZE-byte kernels
//
// Purpose: after start, reads num_kernels*KSIZE consecutive bytes beginning at
// base_addr, packs every KSIZE bytes into one kernel word (byte i in bits
// [8i+7:8i]) and presents each kernel on a valid/ready handshake.
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-high
//   start        one-cycle job request, honoured only when idle
//   base_addr    first byte address, sampled with start
//   num_kernels  kernels in the job, sampled with start (0 = immediate done)
//   bus          master side of conv_weight_streamer_if (RAM port + kernel stream)
//   busy         high while a job is in flight
//   done         one-cycle pulse when a job finishes
module conv_weight_streamer #(
  parameter int ADDR_W = 16,
  parameter int KSIZE  = 9,
  parameter int CNT_W  = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [CNT_W-1:0]     num_kernels,
  conv_weight_streamer_if.master bus,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = $clog2(KSIZE + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_TAIL    = 2'd2;
  localparam logic [1:0] S_PRESENT = 2'd3;

  logic [1:0]       state;
  logic [IW-1:0]    issued;     // addresses issued for the current kernel, including the one on ram_addr
  logic [CNT_W-1:0] remaining;  // kernels still to be handed off, including the one in progress
  logic [IW-1:0]    cap_idx;

  // RAM data lags the address by one cycle, so the byte arriving now belongs
  // to the address issued two counts back.
  assign cap_idx = issued - IW'(2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      issued       <= '0;
      remaining    <= '0;
      bus.ram_addr <= '0;
      bus.k_data   <= '0;
      bus.k_valid  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (num_kernels != '0) begin
              bus.ram_addr <= base_addr;
              remaining    <= num_kernels;
              issued       <= IW'(1);
              busy         <= 1'b1;
              state        <= S_FETCH;
            end else begin
              done <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          if (issued >= IW'(2)) begin
            bus.k_data[8*cap_idx +: 8] <= bus.ram_q;
          end
          if (issued == IW'(KSIZE)) begin
            state <= S_TAIL;
          end else begin
            bus.ram_addr <= bus.ram_addr + 1'b1;
            issued       <= issued + 1'b1;
          end
        end

        S_TAIL: begin
          bus.k_data[8*(KSIZE-1) +: 8] <= bus.ram_q;
          bus.k_valid                  <= 1'b1;
          state                        <= S_PRESENT;
        end

        S_PRESENT: begin
          if (bus.k_ready) begin
            bus.k_valid <= 1'b0;
            remaining   <= remaining - 1'b1;
            if (remaining != CNT_W'(1)) begin
              // Kernels are contiguous: the next one starts right after the last byte.
              bus.ram_addr <= bus.ram_addr + 1'b1;
              issued       <= IW'(1);
              state        <= S_FETCH;
            end else begin
              issued <= '0;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= S_IDLE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
